pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline-stage register that generalises the fixed MEM/WB latch.
- Carries a CTRL_W control field and a DATA_W payload between adjacent stages with valid/ready flow control, a synchronous flush and an optional 2-entry skid buffer.
- Control bits are forced to zero whenever the stage holds a bubble, so write-enables never fire on empty slots.
- Instantiated between EX/MEM and MEM/WB; used wherever back-pressure from a multi-cycle memory must be absorbed.

Parameters:
- DATA_W, 69, payload width (default packs mem_data 32 + alu_out 32 + rd 5).
- CTRL_W, 2, control field width (default RegWrite, MemToReg); zeroed on bubble.
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  discard all held entries (branch or exception squash).
- in_valid  in  1  upstream holds a valid entry.
- in_ready  out  1  stage accepts an entry this cycle.
- in_ctrl  in  CTRL_W  upstream control bits.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  stage presents a valid entry.
- out_ready  in  1  downstream consumes the entry this cycle.
- out_ctrl  out  CTRL_W  control bits; all-zero when out_valid=0.
- out_data  out  DATA_W  payload; holds the last value when out_valid=0.
- occupancy  out  2  number of held entries (0..2; maximum 1 when SKID=0).

Behaviour:
- Handshake:
  - Accept when in_valid && in_ready.
  - Consume when out_valid && out_ready.
  - All state updates on posedge clk only.
- Reset (rst=1 at an edge):
  - out_valid=0, out_ctrl=0, out_data=0, occupancy=0.
  - Skid entry cleared.
  - in_ready=1 the following cycle.
  - rst has priority over flush and all handshakes.
- Flush (rst=0, flush=1):
  - Next cycle occupancy=0, out_valid=0, out_ctrl=0.
  - A same-cycle accept is dropped; a same-cycle consume still counts downstream.
  - out_data is not cleared.
- SKID=1 state machine on occupancy:
  - EMPTY(0): in_ready=1. Accept -> ONE; the entry appears on out_* next cycle (latency 1).
  - ONE(1), in_ready=1:
    - Accept and consume -> ONE; the new entry replaces the output.
    - Accept, no consume -> TWO; the new entry goes to the skid register.
    - Consume only -> EMPTY.
    - Neither -> hold.
  - TWO(2), in_ready=0:
    - Consume -> ONE; the skid entry moves to the output register.
    - No consume -> hold. Upstream must hold its data.
  - in_ready is a direct register output (no combinational path from out_ready).
- SKID=0:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept loads the output register; consume without accept -> empty.
- Bubble gating: out_ctrl = out_valid ? stored_ctrl : 0. A stall or flush therefore never replays RegWrite.
- Ordering: entries leave in acceptance order. No duplication and no loss except under flush or rst.
- Widths: no arithmetic. The occupancy counter saturates by construction; values 2 with SKID=0, or 3, are illegal (assertion).

Decomposition:
- Shared pipeline package holds:
  - default field widths: REG_ADDR_W=5, XLEN=32.
  - MEM/WB control-field bit indices: CTRL_REGWRITE=0, CTRL_MEMTOREG=1.
  - A helper constant for the packed payload width.
- One natural sub-module: pipe_slot. It is a single valid+ctrl+data register with load/clear enables and is instantiated twice (output slot, skid slot). The top contains only the occupancy FSM and muxing.

Test Plan:
- Reset, then in_valid=1, in_ctrl=2'b11, in_data=69'h1234, out_ready=1 -> next cycle out_valid=1, out_ctrl=2'b11, out_data=69'h1234, occupancy=1.
- SKID=1, out_ready=0, push A then B -> occupancy=2, in_ready=0, out_data=A. Raise out_ready -> A consumed, then B on the output, then empty; in_ready returns to 1 one cycle after the first consume.
- Full (occupancy=2), flush=1 with in_valid=1 on the same cycle -> next cycle occupancy=0, out_valid=0, out_ctrl=0, incoming entry lost, in_ready=1.
- Stall with an empty stage: out_ready=0, in_valid=0 for 5 cycles -> out_ctrl stays 2'b00 throughout, so no spurious RegWrite.
- Random valid/ready streams of 1000 entries, SKID=0 and SKID=1 -> scoreboard shows in-order delivery, no loss or duplication, and occupancy never exceeds the limit.
- Mid-stream reset: rst=1 while occupancy=2 -> next cycle all outputs zero, occupancy=0; rst asserted together with flush gives the same result.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: MEM/WB field widths, control-bit indices and
// the occupancy encoding used by the pipeline-stage register.
package pipe_stage_reg_pkg;

   localparam int REG_ADDR_W    = 5;
   localparam int XLEN          = 32;

   localparam int CTRL_REGWRITE = 0;
   localparam int CTRL_MEMTOREG = 1;
   localparam int MEMWB_CTRL_W  = 2;

   // mem_data + alu_out + rd
   localparam int MEMWB_PAYLOAD_W = 2 * XLEN + REG_ADDR_W;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_e;

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// Single pipeline slot: valid + ctrl + data register with load and clear.
// Clear drops valid and ctrl but keeps the payload.
module pipe_slot #(
   parameter int CTRL_W = 2,
   parameter int DATA_W = 69
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clr,
   input  logic [CTRL_W-1:0] ctrl_in,
   input  logic [DATA_W-1:0] data_in,
   output logic              valid,
   output logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] data
);

   logic              valid_q, valid_d;
   logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
   logic [DATA_W-1:0] data_q,  data_d;

   always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      data_d  = data_q;
      if (clr) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
      end else if (load) begin
         valid_d = 1'b1;
         ctrl_d  = ctrl_in;
         data_d  = data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign ctrl  = ctrl_q;
   assign data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-stage register with valid/ready flow control, flush
// and an optional two-entry skid buffer.
//
//   state     | meaning
//   OCC_EMPTY | no entry held, in_ready=1
//   OCC_ONE   | output slot valid, skid slot empty
//   OCC_TWO   | output and skid slots valid, in_ready=0 (SKID=1 only)
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int DATA_W = MEMWB_PAYLOAD_W,
   parameter int CTRL_W = MEMWB_CTRL_W,
   parameter int SKID   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   occ_e state_q, state_d;
   logic in_ready_q, in_ready_d;
   logic accept, consume;
   logic out_load, out_clr, out_from_skid, skid_load, skid_clr;
   logic              out_v, skid_v;
   logic [CTRL_W-1:0] out_c, skid_c, out_c_in;
   logic [DATA_W-1:0] out_d, skid_d, out_d_in;

   assign in_ready = (SKID != 0) ? in_ready_q : (!out_v || out_ready);
   assign accept   = in_valid && in_ready;
   assign consume  = out_v && out_ready;

   always_comb begin
      state_d       = state_q;
      out_load      = 1'b0;
      out_clr       = 1'b0;
      out_from_skid = 1'b0;
      skid_load     = 1'b0;
      skid_clr      = 1'b0;
      if (flush) begin
         state_d  = OCC_EMPTY;
         out_clr  = 1'b1;
         skid_clr = 1'b1;
      end else begin
         unique case (state_q)
            OCC_EMPTY: begin
               if (accept) begin
                  out_load = 1'b1;
                  state_d  = OCC_ONE;
               end
            end
            OCC_ONE: begin
               // without a skid slot an accept here always coincides with a consume
               if (accept && consume) begin
                  out_load = 1'b1;
               end else if (accept) begin
                  skid_load = 1'b1;
                  state_d   = OCC_TWO;
               end else if (consume) begin
                  out_clr = 1'b1;
                  state_d = OCC_EMPTY;
               end
            end
            OCC_TWO: begin
               if (consume) begin
                  out_load      = 1'b1;
                  out_from_skid = 1'b1;
                  skid_clr      = 1'b1;
                  state_d       = OCC_ONE;
               end
            end
            default: state_d = OCC_EMPTY;
         endcase
      end
      in_ready_d = (state_d != OCC_TWO);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= OCC_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign out_c_in = out_from_skid ? skid_c : in_ctrl;
   assign out_d_in = out_from_skid ? skid_d : in_data;

   pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_out_slot (
      .clk     (clk),
      .rst     (rst),
      .load    (out_load),
      .clr     (out_clr),
      .ctrl_in (out_c_in),
      .data_in (out_d_in),
      .valid   (out_v),
      .ctrl    (out_c),
      .data    (out_d)
   );

   pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid_slot (
      .clk     (clk),
      .rst     (rst),
      .load    (skid_load),
      .clr     (skid_clr),
      .ctrl_in (in_ctrl),
      .data_in (in_data),
      .valid   (skid_v),
      .ctrl    (skid_c),
      .data    (skid_d)
   );

   assign out_valid = out_v;
   assign out_ctrl  = out_v ? out_c : '0;
   assign out_data  = out_d;
   assign occupancy = state_q;

   a_occ_legal: assert property (@(posedge clk) disable iff (rst)
      (state_q != 2'd3) && ((SKID != 0) || (state_q != OCC_TWO)));

   a_skid_consistent: assert property (@(posedge clk) disable iff (rst)
      skid_v == (state_q == OCC_TWO));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed checks on the skid variant, then random
// valid/ready streams on both variants against a queue-based scoreboard.
module tb_pipe_stage_reg;
   import pipe_stage_reg_pkg::*;

   localparam int DW = MEMWB_PAYLOAD_W;
   localparam int N  = 1000;

   typedef struct {
      logic [1:0]    c;
      logic [DW-1:0] d;
   } ent_t;

   logic clk = 1'b0;
   logic rst, flush;
   logic          in_valid [2];
   logic          in_ready [2];
   logic [1:0]    in_ctrl  [2];
   logic [DW-1:0] in_data  [2];
   logic          out_valid[2];
   logic          out_ready[2];
   logic [1:0]    out_ctrl [2];
   logic [DW-1:0] out_data [2];
   logic [1:0]    occupancy[2];

   int   tests = 0;
   int   fails = 0;
   logic chk_en = 1'b0;
   ent_t sb0[$];
   ent_t sb1[$];

   always #5 clk = ~clk;

   // index 0: single entry (SKID=0); index 1: skid buffer (SKID=1)
   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(2), .SKID(0)) u_noskid (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_ctrl(in_ctrl[0]), .in_data(in_data[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_ctrl(out_ctrl[0]),
      .out_data(out_data[0]), .occupancy(occupancy[0]));

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(2), .SKID(1)) u_skid (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_ctrl(in_ctrl[1]), .in_data(in_data[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_ctrl(out_ctrl[1]),
      .out_data(out_data[1]), .occupancy(occupancy[1]));

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push2(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b);
      in_valid[k] = 1'b1;
      in_ctrl[k]  = 2'b11;
      in_data[k]  = a;
      step();
      in_data[k]  = b;
      step();
      in_valid[k] = 1'b0;
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_valid"}, DW'(out_valid[1]), '0);
      chk({tag, "_ctrl"},  DW'(out_ctrl[1]),  '0);
      chk({tag, "_data"},  out_data[1],       '0);
      chk({tag, "_occ"},   DW'(occupancy[1]), '0);
      chk({tag, "_inrdy"}, DW'(in_ready[1]),  DW'(1));
   endtask

   // Scoreboard: the stage holds exactly the accepted-but-unconsumed entries.
   task automatic mon(input int k);
      int   sz;
      ent_t e;
      sz = (k == 0) ? sb0.size() : sb1.size();
      chk($sformatf("occ_vs_model%0d", k), DW'(occupancy[k]), DW'(sz));
      chk($sformatf("valid_vs_model%0d", k), DW'(out_valid[k]), DW'(sz != 0));
      chk($sformatf("occ_limit%0d", k), DW'(occupancy[k] <= 2'(k + 1)), DW'(1));
      if (!out_valid[k]) chk($sformatf("bubble_ctrl%0d", k), DW'(out_ctrl[k]), '0);
      if (out_valid[k] && out_ready[k]) begin
         if (sz == 0) begin
            chk($sformatf("unexpected_out%0d", k), DW'(1), '0);
         end else begin
            if (k == 0) e = sb0.pop_front();
            else        e = sb1.pop_front();
            chk($sformatf("sb_data%0d", k), out_data[k], e.d);
            chk($sformatf("sb_ctrl%0d", k), DW'(out_ctrl[k]), DW'(e.c));
         end
      end
      if (in_valid[k] && in_ready[k]) begin
         e.c = in_ctrl[k];
         e.d = in_data[k];
         if (k == 0) sb0.push_back(e);
         else        sb1.push_back(e);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         mon(0);
         mon(1);
      end
   end

   task automatic drive(input int k);
      int          sent;
      logic        fired;
      logic [95:0] r;
      int          i;
      sent = 0;
      while (sent < N) begin
         @(negedge clk);
         fired = in_valid[k] && in_ready[k];
         if (fired) sent++;
         @(posedge clk);
         #1;
         if (fired || !in_valid[k]) begin
            if (sent < N) begin
               in_valid[k] = ($urandom_range(3) != 0);
               in_ctrl[k]  = 2'($urandom_range(3));
               r = {$urandom, $urandom, $urandom};
               in_data[k]  = r[DW-1:0];
            end else begin
               in_valid[k] = 1'b0;
            end
         end
         out_ready[k] = ($urandom_range(2) != 0);
      end
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b1;
      i = 0;
      while (occupancy[k] != 2'd0 && i < 50) begin
         step();
         i++;
      end
      chk($sformatf("drain_timeout%0d", k), DW'(occupancy[k]), '0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1);
   end

   initial begin
      rst   = 1'b1;
      flush = 1'b0;
      for (int k = 0; k < 2; k++) begin
         in_valid[k]  = 1'b0;
         in_ctrl[k]   = '0;
         in_data[k]   = '0;
         out_ready[k] = 1'b0;
      end
      step();
      rst = 1'b0;
      check_cleared("reset");

      // first entry appears one cycle after accept
      in_valid[1]  = 1'b1;
      in_ctrl[1]   = 2'b11;
      in_data[1]   = DW'(69'h1234);
      out_ready[1] = 1'b1;
      step();
      in_valid[1] = 1'b0;
      chk("first_valid", DW'(out_valid[1]), DW'(1));
      chk("first_ctrl",  DW'(out_ctrl[1]),  DW'(2'b11));
      chk("first_data",  out_data[1],       DW'(69'h1234));
      chk("first_occ",   DW'(occupancy[1]), DW'(1));
      step();
      chk("first_drain", DW'(occupancy[1]), '0);
      out_ready[1] = 1'b0;

      // fill the skid buffer, then drain it
      push2(1, DW'(69'hA), DW'(69'hB));
      chk("full_occ",   DW'(occupancy[1]), DW'(2));
      chk("full_inrdy", DW'(in_ready[1]),  '0);
      chk("full_data",  out_data[1],       DW'(69'hA));
      out_ready[1] = 1'b1;
      step();
      chk("pop1_occ",   DW'(occupancy[1]), DW'(1));
      chk("pop1_data",  out_data[1],       DW'(69'hB));
      chk("pop1_inrdy", DW'(in_ready[1]),  DW'(1));
      step();
      chk("pop2_valid", DW'(out_valid[1]), '0);
      chk("pop2_occ",   DW'(occupancy[1]), '0);
      out_ready[1] = 1'b0;

      // flush while full with a simultaneous push
      push2(1, DW'(69'hC), DW'(69'hD));
      flush       = 1'b1;
      in_valid[1] = 1'b1;
      in_data[1]  = DW'(69'hE);
      step();
      flush       = 1'b0;
      in_valid[1] = 1'b0;
      chk("flush_occ",   DW'(occupancy[1]), '0);
      chk("flush_valid", DW'(out_valid[1]), '0);
      chk("flush_ctrl",  DW'(out_ctrl[1]),  '0);
      chk("flush_inrdy", DW'(in_ready[1]),  DW'(1));
      chk("flush_data_kept", out_data[1],   DW'(69'hC));
      step();
      chk("flush_drop", DW'(out_valid[1]), '0);

      // empty stall: control must stay zero
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_ctrl", DW'(out_ctrl[1]), '0);
      end

      // combinational in_ready without skid
      in_valid[0] = 1'b1;
      in_ctrl[0]  = 2'b01;
      in_data[0]  = DW'(69'h55);
      step();
      in_valid[0] = 1'b0;
      chk("noskid_occ",   DW'(occupancy[0]), DW'(1));
      chk("noskid_block", DW'(in_ready[0]),  '0);
      out_ready[0] = 1'b1;
      #1;
      chk("noskid_pass", DW'(in_ready[0]), DW'(1));
      step();
      chk("noskid_empty", DW'(occupancy[0]), '0);
      out_ready[0] = 1'b0;

      // mid-stream reset, alone and together with flush
      push2(1, DW'(69'h11), DW'(69'h22));
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_cleared("rst_mid");
      push2(1, DW'(69'h33), DW'(69'h44));
      rst   = 1'b1;
      flush = 1'b1;
      step();
      rst   = 1'b0;
      flush = 1'b0;
      check_cleared("rst_flush");

      // random streams on both variants
      chk_en = 1'b1;
      fork
         drive(0);
         drive(1);
      join
      step();
      chk_en = 1'b0;
      chk("sb_left0", DW'(sb0.size()), '0);
      chk("sb_left1", DW'(sb1.size()), '0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
